muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit for the femtoRV32 core. It is the parametrised successor to the combinational ALU-select decode: it decodes funct3 of an M-extension instruction and executes it over multiple cycles. It sits beside the single-cycle ALU in the execute stage. It uses a valid/ready handshake so the core can stall on it, and a kill input so a pipeline flush can abandon an operation in progress.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_decode.sv | 25 ++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes,
// FSM state encoding and the decoded control bundle.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic is_div;
        logic is_rem;
        logic a_signed;
        logic b_signed;
        logic want_high;
    } ctrl_t;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational funct3 -> control bundle decode for M-extension ops; also
// usable by hazard logic that needs to classify an op early.
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic [2:0] funct3,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.is_div    = funct3[2];
        ctrl.is_rem    = funct3[2] & funct3[1];
        ctrl.want_high = !funct3[2] && (funct3[1:0] != 2'b00);
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                ctrl.a_signed = 1'b1;
                ctrl.b_signed = 1'b1;
            end
            F3_MULHSU: ctrl.a_signed = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with valid/ready handshake and kill.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    ctrl_t              dec_ctrl;
    ctrl_t              ctrl_reg;
    state_t             state_reg;
    logic [2*XLEN-1:0]  acc_reg;
    logic [XLEN:0]      b_mag_reg;
    logic               a_msb_reg;
    logic               b_msb_reg;
    logic               special_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [XLEN-1:0]    result_reg;
    logic               out_valid_reg;

    muldiv_decode u_decode (
        .funct3 (funct3),
        .ctrl   (dec_ctrl)
    );

    // Operand magnitudes at acceptance; the most-negative value is
    // representable as an unsigned magnitude, so nothing overflows.
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN:0]      b_ext;
    logic [XLEN:0]      b_mag;
    logic               div_zero;
    logic               div_ovf;
    logic               is_special;
    logic [2*XLEN-1:0]  special_acc;

    assign a_neg       = dec_ctrl.a_signed & op_a[XLEN-1];
    assign b_neg       = dec_ctrl.b_signed & op_b[XLEN-1];
    assign a_mag       = a_neg ? (~op_a + 1'b1) : op_a;
    assign b_ext       = {b_neg, op_b};
    assign b_mag       = b_neg ? (~b_ext + 1'b1) : b_ext;
    assign div_zero    = (op_b == '0);
    assign div_ovf     = dec_ctrl.a_signed && (op_a == MOST_NEG) && (op_b == '1);
    assign is_special  = dec_ctrl.is_div && (div_zero || div_ovf);
    // Special results are preloaded as {remainder, quotient}, already final.
    assign special_acc = div_zero ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, op_a};

    // One multiply step: conditional add into the high half, then shift right.
    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? b_mag_reg : '0);
    assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

    // One restoring-divide step on {remainder, dividend/quotient}.
    logic [XLEN:0]      div_trial;
    logic               div_ok;
    logic [XLEN-1:0]    div_rem;
    logic [2*XLEN-1:0]  div_next;
    assign div_trial = acc_reg[2*XLEN-1:XLEN-1] - b_mag_reg;
    assign div_ok    = !div_trial[XLEN];
    assign div_rem   = div_ok ? div_trial[XLEN-1:0] : acc_reg[2*XLEN-2:XLEN-1];
    assign div_next  = {div_rem, acc_reg[XLEN-2:0], div_ok};

    // Sign fix-up and output selection.
    logic               res_neg;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    div_sel;
    logic [XLEN-1:0]    div_fix;
    logic [XLEN-1:0]    fix_val;
    assign res_neg  = !special_reg &&
                      ((ctrl_reg.a_signed & a_msb_reg) ^
                       (!ctrl_reg.is_rem & ctrl_reg.b_signed & b_msb_reg));
    assign prod_fix = res_neg ? (~acc_reg + 1'b1) : acc_reg;
    assign div_sel  = ctrl_reg.is_rem ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
    assign div_fix  = res_neg ? (~div_sel + 1'b1) : div_sel;
    assign fix_val  = ctrl_reg.is_div   ? div_fix :
                      ctrl_reg.want_high ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ctrl_reg      <= '0;
            acc_reg       <= '0;
            b_mag_reg     <= '0;
            a_msb_reg     <= 1'b0;
            b_msb_reg     <= 1'b0;
            special_reg   <= 1'b0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else if (kill) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        ctrl_reg    <= dec_ctrl;
                        b_mag_reg   <= b_mag;
                        a_msb_reg   <= op_a[XLEN-1];
                        b_msb_reg   <= op_b[XLEN-1];
                        special_reg <= is_special;
                        cnt_reg     <= CNT_W'(XLEN);
                        if (is_special) begin
                            acc_reg   <= special_acc;
                            state_reg <= FIX;
                        end else begin
                            acc_reg   <= {{XLEN{1'b0}}, a_mag};
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_reg <= ctrl_reg.is_div ? div_next : mul_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1))
                        state_reg <= FIX;
                end
                FIX: begin
                    result_reg    <= fix_val;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic, latency, special cases,
// backpressure, kill and asynchronous reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for out_valid; does not consume.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res);
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = '0; op_b = '0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        res = result;
        $display("op f3=%0d a=%08h b=%08h -> result=%08h latency=%0d", f3, a, b, res, lat);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        kill = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset: out_valid=%b busy=%b in_ready=%b result=%08h, required 0 0 1 00000000",
                     out_valid, busy, in_ready, result);
        end
        $display("reset: out_valid=%b busy=%b in_ready=%b result=%08h", out_valid, busy, in_ready, result);
    endtask

    task automatic test_mul();
        int lat;
        int busy_drop;
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; busy_drop = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (!busy) busy_drop++;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        $display("op MUL a=00000007 b=fffffffd -> result=%08h latency=%0d", result, lat);
        checks++;
        if (lat != 33) begin
            errors++;
            $display("FAIL mul_latency: got %0d, required 33", lat);
        end
        checks++;
        if (result !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mul_result: got %08h, required ffffffeb", result);
        end
        checks++;
        if (busy_drop != 0) begin
            errors++;
            $display("FAIL mul_busy: busy low for %0d cycles, required 0", busy_drop);
        end
        consume();
    endtask

    task automatic test_mulh();
        logic [2:0]  f3 [3];
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic [31:0] ev [3];
        int lat;
        logic [31:0] res;
        f3[0] = 3'b001; av[0] = 32'h80000000; bv[0] = 32'h80000000; ev[0] = 32'h40000000;
        f3[1] = 3'b011; av[1] = 32'hFFFFFFFF; bv[1] = 32'hFFFFFFFF; ev[1] = 32'hFFFFFFFE;
        f3[2] = 3'b010; av[2] = 32'hFFFFFFFF; bv[2] = 32'hFFFFFFFF; ev[2] = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            do_op(f3[k], av[k], bv[k], lat, res);
            checks++;
            if (res !== ev[k]) begin
                errors++;
                $display("FAIL mulh_%0d: got %08h, required %08h", k, res, ev[k]);
            end
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3 [4];
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [31:0] ev [4];
        int lat;
        logic [31:0] res;
        f3[0] = 3'b100; av[0] = 32'hFFFFFFF9; bv[0] = 32'd2;  ev[0] = 32'hFFFFFFFD;
        f3[1] = 3'b110; av[1] = 32'hFFFFFFF9; bv[1] = 32'd2;  ev[1] = 32'hFFFFFFFF;
        f3[2] = 3'b101; av[2] = 32'd100;      bv[2] = 32'd7;  ev[2] = 32'd14;
        f3[3] = 3'b111; av[3] = 32'd100;      bv[3] = 32'd7;  ev[3] = 32'd2;
        for (int k = 0; k < 4; k++) begin
            do_op(f3[k], av[k], bv[k], lat, res);
            checks++;
            if (res !== ev[k] || lat != 33) begin
                errors++;
                $display("FAIL div_%0d: got %08h lat %0d, required %08h lat 33", k, res, lat, ev[k]);
            end
            consume();
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3 [4];
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [31:0] ev [4];
        int lat;
        logic [31:0] res;
        f3[0] = 3'b100; av[0] = 32'd5;        bv[0] = 32'd0;        ev[0] = 32'hFFFFFFFF;
        f3[1] = 3'b111; av[1] = 32'd5;        bv[1] = 32'd0;        ev[1] = 32'd5;
        f3[2] = 3'b100; av[2] = 32'h80000000; bv[2] = 32'hFFFFFFFF; ev[2] = 32'h80000000;
        f3[3] = 3'b110; av[3] = 32'h80000000; bv[3] = 32'hFFFFFFFF; ev[3] = 32'h00000000;
        for (int k = 0; k < 4; k++) begin
            do_op(f3[k], av[k], bv[k], lat, res);
            checks++;
            if (res !== ev[k]) begin
                errors++;
                $display("FAIL special_%0d_result: got %08h, required %08h", k, res, ev[k]);
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL special_%0d_latency: got %0d, required 1", k, lat);
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        logic [31:0] res;
        do_op(3'b000, 32'd3, 32'd5, lat, res);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3; in_valid = 1'b1;
            if (result !== 32'd15 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        $display("backpressure: held result=%08h bad_cycles=%0d", result, bad);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d bad cycles, required 0", bad);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
        do_op(3'b101, 32'd9, 32'd3, lat, res);
        checks++;
        if (res !== 32'd3 || lat != 33) begin
            errors++;
            $display("FAIL after_backpressure: got %08h lat %0d, required 00000003 lat 33", res, lat);
        end
        consume();
    endtask

    task automatic test_kill();
        int seen;
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL kill_idle: busy=%b in_ready=%b, required 0 1", busy, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        $display("kill: busy=%b out_valid_cycles=%0d", busy, seen);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL kill_no_result: out_valid high %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [31:0] res;
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd50; op_b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: out_valid=%b busy=%b result=%08h", out_valid, busy, result);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b busy=%b result=%08h, required 0 0 00000000",
                     out_valid, busy, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b111, 32'd50, 32'd7, lat, res);
        checks++;
        if (res !== 32'd1 || lat != 33) begin
            errors++;
            $display("FAIL after_reset: got %08h lat %0d, required 00000001 lat 33", res, lat);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_to_back();
        test_kill();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
